// File: rtl/uart_pkg.sv
// Shared types for the BLE command-link UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  localparam int DEFAULT_BAUD_DIV = 2604;

endpackage

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver, mid-bit sampled; rdy rises ~2 + BAUD_DIV/2 + 9*BAUD_DIV cycles after the start edge.
// No backpressure: rdy/clr_rdy handshake, a byte completed while rdy is still set overwrites and pulses ovr_err.
module uart_cmd_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       ovr_err
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  rx_state_t     state, state_nxt;
  logic          rx_ff1, rx_s;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          sample;
  logic          load_half, load_full, shift_en, clr_bits, complete, frame_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ff1 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      rx_ff1 <= RX;
      rx_s   <= rx_ff1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign sample = (baud_cnt == '0);

  always_comb begin
    state_nxt = state;
    load_half = 1'b0;
    load_full = 1'b0;
    shift_en  = 1'b0;
    clr_bits  = 1'b0;
    complete  = 1'b0;
    frame_bad = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          load_half = 1'b1;
        end
      end
      START: begin
        if (sample) begin
          load_full = 1'b1;
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
            clr_bits  = 1'b1;
          end
        end
      end
      DATA: begin
        if (sample) begin
          load_full = 1'b1;
          shift_en  = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          load_full = 1'b1;
          if (rx_s) begin
            complete  = 1'b1;
            state_nxt = IDLE;
          end else begin
            frame_bad = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      // A held-low line must return high before another start is accepted.
      BREAK: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt <= '0;
    end else if (load_half) begin
      baud_cnt <= HALF_LOAD;
    end else if (load_full) begin
      baud_cnt <= FULL_LOAD;
    end else if (state == START || state == DATA || state == STOP) begin
      baud_cnt <= baud_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= 3'd0;
      shift   <= 8'hFF;
    end else begin
      if (clr_bits)      bit_cnt <= 3'd0;
      else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
      if (shift_en)      shift   <= {rx_s, shift[7:1]};
    end
  end

  // Completion takes priority over a same-cycle clr_rdy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data <= 8'h00;
      rdy     <= 1'b0;
      frm_err <= 1'b0;
      ovr_err <= 1'b0;
    end else begin
      frm_err <= frame_bad;
      ovr_err <= complete & rdy & ~clr_rdy;
      if (complete) begin
        rx_data <= shift;
        rdy     <= 1'b1;
      end else if (clr_rdy) begin
        rdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: directed scenarios plus random frames against a frame-level reference model.
module tb_uart_cmd_rx;

  localparam int B = 16;

  logic       clk = 1'b0;
  logic       rst, RX, clr_rdy;
  logic [7:0] rx_data;
  logic       rdy, frm_err, ovr_err;

  int checks = 0;
  int errors = 0;
  int frm_seen = 0;
  int ovr_seen = 0;

  logic [7:0] m_data;
  logic       m_rdy;
  int         m_frm, m_ovr;

  uart_cmd_rx #(.BAUD_DIV(B)) dut (
    .clk     (clk),
    .rst     (rst),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err),
    .ovr_err (ovr_err)
  );

  always #5 clk = ~clk;

  // Error outputs are one-cycle pulses, so high cycles equal events.
  always @(negedge clk) begin
    if (frm_err) frm_seen++;
    if (ovr_err) ovr_seen++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, want completion)");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_data"}, 32'(rx_data), 32'(m_data));
    check({tag, "_rdy"},  32'(rdy),     32'(m_rdy));
    check({tag, "_frm"},  frm_seen,     m_frm);
    check({tag, "_ovr"},  ovr_seen,     m_ovr);
  endtask

  task automatic model_frame(input logic [7:0] d, input logic stop_ok);
    if (stop_ok) begin
      if (m_rdy) m_ovr++;
      m_data = d;
      m_rdy  = 1'b1;
    end else begin
      m_frm++;
    end
  endtask

  task automatic idle_line(input int n, input logic level);
    RX = level;
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_pulse();
    RX      = 1'b1;
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
    m_rdy   = 1'b0;
  endtask

  // One frame at B cycles per bit; optional clr_rdy / rst one-cycle pulse at a given cycle index.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int clr_at, input int rst_at);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int c = 0; c < 10 * B; c++) begin
      RX      = bits[c / B];
      clr_rdy = (c == clr_at);
      rst     = (c == rst_at);
      if (rst_at >= 0 && c == rst_at + 1) begin
        check("midrst_rdy",  32'(rdy),     32'd0);
        check("midrst_data", 32'(rx_data), 32'h00);
      end
      @(negedge clk);
    end
    clr_rdy = 1'b0;
    rst     = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic       stop_ok;
    int         gap;

    RX = 1'b1; clr_rdy = 1'b0; rst = 1'b1;
    m_data = 8'h00; m_rdy = 1'b0; m_frm = 0; m_ovr = 0;
    repeat (3) @(negedge clk);
    check("reset_data", 32'(rx_data), 32'h00);
    check("reset_rdy",  32'(rdy),     32'd0);
    check("reset_frm",  32'(frm_err), 32'd0);
    check("reset_ovr",  32'(ovr_err), 32'd0);
    rst = 1'b0;
    idle_line(4, 1'b1);

    send_frame(8'hA5, 1'b1, -1, -1);
    model_frame(8'hA5, 1'b1);
    check_state("a5");
    clr_pulse();
    check_state("a5_clr");

    send_frame(8'h47, 1'b1, -1, -1);
    model_frame(8'h47, 1'b1);
    send_frame(8'h52, 1'b1, -1, -1);
    model_frame(8'h52, 1'b1);
    check_state("b2b");
    clr_pulse();

    idle_line(B / 4, 1'b0);
    idle_line(2 * B, 1'b1);
    check_state("false_start");
    send_frame(8'h3C, 1'b1, -1, -1);
    model_frame(8'h3C, 1'b1);
    check_state("after_false");
    clr_pulse();

    send_frame(8'h0F, 1'b0, -1, -1);
    model_frame(8'h0F, 1'b0);
    idle_line(5 * B, 1'b0);
    check_state("framing");
    idle_line(4, 1'b1);
    send_frame(8'h55, 1'b1, -1, -1);
    model_frame(8'h55, 1'b1);
    check_state("after_break");

    send_frame(8'hFF, 1'b1, -1, 5 * B + B / 2);
    m_data = 8'h00; m_rdy = 1'b0;
    idle_line(2 * B, 1'b1);
    check_state("midrst");
    send_frame(8'hC3, 1'b1, -1, -1);
    model_frame(8'hC3, 1'b1);
    check_state("after_rst");

    // rdy is still set from C3; clr_rdy lands in the stop-bit sample cycle.
    send_frame(8'h9A, 1'b1, 2 + B / 2 + 9 * B, -1);
    m_data = 8'h9A; m_rdy = 1'b1;
    check_state("clr_at_done");
    clr_pulse();

    for (int i = 0; i < 24; i++) begin
      d       = 8'($urandom);
      stop_ok = ($urandom_range(0, 5) != 0);
      send_frame(d, stop_ok, -1, -1);
      model_frame(d, stop_ok);
      check_state("rand");
      gap = stop_ok ? $urandom_range(0, B) : $urandom_range(2, B);
      RX = 1'b1;
      if (gap > 0 && $urandom_range(0, 1) == 1) begin
        clr_pulse();
        gap--;
        check("rand_clr_rdy", 32'(rdy), 32'd0);
      end
      idle_line(gap, 1'b1);
    end

    idle_line(4, 1'b1);
    check_state("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
